// File: rtl/prog_loader.sv
// Boot loader for the RAT 1024x18 program memory: byte stream in, sequential word writes out.
// Optional trailing XOR checksum byte enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1024
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   input  logic [7:0]        RX_DATA,
   input  logic              RX_VALID,
   output logic              RX_READY,
   output logic              WE,
   output logic [ADDR_W-1:0] WADDR,
   output logic [17:0]       WDATA,
   output logic              CPU_RST,
   output logic              BUSY,
   output logic              DONE,
   output logic              ERR
);

   typedef enum logic [3:0] {
      IDLE, CNT_HI, CNT_LO, W_B0, W_B1, W_B2, WRITE,
`ifdef PROG_LOADER_CHECKSUM_EN
      CHK,
`endif
      DONE_S, ERR_S
   } state_t;

   localparam logic [16:0] DEPTH_V = 17'(DEPTH);

   state_t            state_q, state_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [ADDR_W:0]   idx_q, idx_d, idx_inc;
   logic [1:0]        b0_q, b0_d;
   logic [7:0]        b1_q, b1_d;
   logic [17:0]       wdata_q, wdata_d;
   logic [15:0]       n_new;
   logic              acc;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0]        chk_q, chk_d;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         b0_q    <= '0;
         b1_q    <= '0;
         wdata_q <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
         chk_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         b0_q    <= b0_d;
         b1_q    <= b1_d;
         wdata_q <= wdata_d;
`ifdef PROG_LOADER_CHECKSUM_EN
         chk_q   <= chk_d;
`endif
      end
   end

   // Outputs decode from registered state only, so RX_READY never depends on RX_VALID.
   always_comb begin
      RX_READY = 1'b0;
      BUSY     = 1'b1;
      unique case (state_q)
         CNT_HI, CNT_LO, W_B0, W_B1, W_B2: RX_READY = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
         CHK:                              RX_READY = 1'b1;
`endif
         IDLE, DONE_S, ERR_S:              BUSY     = 1'b0;
         default:                          ;
      endcase
   end

   assign WE      = (state_q == WRITE);
   assign DONE    = (state_q == DONE_S);
   assign ERR     = (state_q == ERR_S);
   assign CPU_RST = BUSY || (state_q == ERR_S);
   assign WADDR   = idx_q[ADDR_W-1:0];
   assign WDATA   = wdata_q;

   assign acc     = RX_VALID && RX_READY;
   assign n_new   = {cnt_q[15:8], RX_DATA};
   assign idx_inc = idx_q + 1'b1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      b0_d    = b0_q;
      b1_d    = b1_q;
      wdata_d = wdata_q;
`ifdef PROG_LOADER_CHECKSUM_EN
      chk_d   = chk_q;
      if (acc && state_q != CHK) chk_d = chk_q ^ RX_DATA;
`endif
      case (state_q)
         IDLE, DONE_S, ERR_S: if (START) begin
            state_d = CNT_HI;
            idx_d   = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            chk_d   = '0;
`endif
         end
         CNT_HI: if (acc) begin
            cnt_d[15:8] = RX_DATA;
            state_d     = CNT_LO;
         end
         CNT_LO: if (acc) begin
            cnt_d[7:0] = RX_DATA;
            state_d    = (n_new == '0 || {1'b0, n_new} > DEPTH_V) ? ERR_S : W_B0;
         end
         W_B0: if (acc) begin
            b0_d    = RX_DATA[1:0];
            state_d = W_B1;
         end
         W_B1: if (acc) begin
            b1_d    = RX_DATA;
            state_d = W_B2;
         end
         W_B2: if (acc) begin
            wdata_d = {b0_q, b1_q, RX_DATA};
            state_d = WRITE;
         end
         WRITE: begin
            idx_d = idx_inc;
            if (32'(idx_inc) == 32'(cnt_q))
`ifdef PROG_LOADER_CHECKSUM_EN
               state_d = CHK;
`else
               state_d = DONE_S;
`endif
            else
               state_d = W_B0;
         end
`ifdef PROG_LOADER_CHECKSUM_EN
         CHK: if (acc) state_d = (RX_DATA == chk_q) ? DONE_S : ERR_S;
`endif
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader; write port is captured into a local memory model.
module tb_prog_loader;
   logic        CLK = 1'b0;
   logic        RST, START, RX_VALID;
   logic [7:0]  RX_DATA;
   logic        RX_READY, WE, CPU_RST, BUSY, DONE, ERR;
   logic [9:0]  WADDR;
   logic [17:0] WDATA;

   prog_loader #(.ADDR_W(10), .DEPTH(1024)) dut (
      .CLK(CLK), .RST(RST), .START(START), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
      .RX_READY(RX_READY), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
      .CPU_RST(CPU_RST), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   int n_chk = 0, n_fail = 0;
   int wr_cnt = 0, first_addr = -1, last_addr = -1;
   logic we_prev = 1'b0;
   logic [17:0] mem     [0:1023];
   logic [17:0] exp_mem [0:1023];
   logic [7:0]  bq [$];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Write-port monitor: single-cycle WE, never while accepting bytes.
   always @(posedge CLK) begin
      if (WE === 1'b1) begin
         chk("we_width", 32'(we_prev), 0);
         chk("we_rdy", 32'(RX_READY), 0);
         mem[WADDR] = WDATA;
         if (wr_cnt == 0) first_addr = int'(WADDR);
         last_addr = int'(WADDR);
         wr_cnt++;
      end
      we_prev = (WE === 1'b1);
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge CLK); #1;
   endtask

   task automatic pulse_start();
      START = 1'b1; tick(); START = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      RX_DATA = b; RX_VALID = 1'b1;
      while (RX_READY !== 1'b1 && n < 20) begin tick(); n++; end
      if (RX_READY !== 1'b1) chk("rx_timeout", 32'(RX_READY), 1);
      else tick();
   endtask

   task automatic send_q(input bit gap, input int nbytes);
      for (int i = 0; i < nbytes; i++) begin
         if (gap) begin
            RX_VALID = 1'b0;
            repeat ($urandom_range(0, 2)) begin
               if (i > 10 && $urandom_range(0, 15) == 0) START = 1'b1;
               tick();
               START = 1'b0;
            end
         end
         send_byte(bq[i]);
      end
      RX_VALID = 1'b0;
   endtask

   task automatic build_img(input int n);
      logic [7:0] x, b0, b1, b2;
      bq.delete();
      bq.push_back(8'(n >> 8)); bq.push_back(8'(n));
      x = 8'(n >> 8) ^ 8'(n);
      for (int w = 0; w < n; w++) begin
         b0 = 8'($urandom_range(0, 255)); b1 = 8'($urandom_range(0, 255));
         b2 = 8'($urandom_range(0, 255));
         bq.push_back(b0); bq.push_back(b1); bq.push_back(b2);
         exp_mem[w] = {b0[1:0], b1, b2};
         x = x ^ b0 ^ b1 ^ b2;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      bq.push_back(x);
`endif
   endtask

   task automatic chk_idle_outs(input string tag);
      chk({tag, "_rdy"},  32'(RX_READY), 0);
      chk({tag, "_we"},   32'(WE), 0);
      chk({tag, "_waddr"}, 32'(WADDR), 0);
      chk({tag, "_wdata"}, 32'(WDATA), 0);
      chk({tag, "_cpurst"}, 32'(CPU_RST), 0);
      chk({tag, "_busy"}, 32'(BUSY), 0);
      chk({tag, "_done"}, 32'(DONE), 0);
      chk({tag, "_err"},  32'(ERR), 0);
   endtask

   initial begin
      int errs;
      logic [7:0] x;
      RST = 1'b1; START = 1'b0; RX_VALID = 1'b0; RX_DATA = 8'h00;
      repeat (3) tick();
      RST = 1'b0; tick();
      chk_idle_outs("reset");

      // Idle with valid data but no START: nothing consumed.
      RX_DATA = 8'hEE; RX_VALID = 1'b1;
      repeat (5) tick();
      chk("idle_rdy", 32'(RX_READY), 0);
      chk("idle_wr", 32'(wr_cnt), 0);

      // Two-word image, RX_VALID held high throughout.
      pulse_start();
      chk("start_busy", 32'(BUSY), 1);
      chk("start_cpurst", 32'(CPU_RST), 1);
      chk("start_rdy", 32'(RX_READY), 1);
      send_byte(8'h00); send_byte(8'h02);
      send_byte(8'h03); send_byte(8'h12); send_byte(8'h34);
      send_byte(8'h01); send_byte(8'hAB); send_byte(8'hCD);
      chk("w2_we", 32'(WE), 1);
      chk("w2_waddr", 32'(WADDR), 1);
      chk("w2_wdata", 32'(WDATA), 32'h1ABCD);
      chk("w2_rdy", 32'(RX_READY), 0);
`ifdef PROG_LOADER_CHECKSUM_EN
      x = 8'h00 ^ 8'h02 ^ 8'h03 ^ 8'h12 ^ 8'h34 ^ 8'h01 ^ 8'hAB ^ 8'hCD;
      send_byte(x);
`else
      tick();
`endif
      RX_VALID = 1'b0;
      chk("w2_done", 32'(DONE), 1);
      chk("w2_cpurst", 32'(CPU_RST), 0);
      chk("w2_busy", 32'(BUSY), 0);
      chk("w2_mem0", 32'(mem[0]), 32'h31234);
      chk("w2_mem1", 32'(mem[1]), 32'h1ABCD);
      chk("w2_cnt", 32'(wr_cnt), 2);

      // Full 1024-word image from DONE_S, with gaps and stray START pulses.
      wr_cnt = 0;
      build_img(1024);
      pulse_start();
      send_q(1'b1, bq.size());
      repeat (2) tick();
      chk("big_done", 32'(DONE), 1);
      chk("big_cnt", 32'(wr_cnt), 1024);
      chk("big_first", 32'(first_addr), 0);
      chk("big_last", 32'(last_addr), 32'h3FF);
      errs = 0;
      for (int i = 0; i < 1024; i++) if (mem[i] !== exp_mem[i]) errs++;
      chk("big_mem", 32'(errs), 0);

      // Over-size count.
      wr_cnt = 0;
      pulse_start();
      send_byte(8'h04); send_byte(8'h01);
      RX_VALID = 1'b0;
      chk("n1025_err", 32'(ERR), 1);
      chk("n1025_cpurst", 32'(CPU_RST), 1);
      chk("n1025_busy", 32'(BUSY), 0);
      repeat (3) tick();
      chk("n1025_nowr", 32'(wr_cnt), 0);

      // Zero count.
      pulse_start();
      send_byte(8'h00); send_byte(8'h00);
      RX_VALID = 1'b0;
      chk("n0_err", 32'(ERR), 1);
      chk("n0_done", 32'(DONE), 0);

      // Reset in the middle of a three-word load.
      build_img(3);
      pulse_start();
      send_q(1'b0, 8);
      chk("mid_busy", 32'(BUSY), 1);
      RST = 1'b1; tick(); RST = 1'b0;
      chk_idle_outs("midrst");
      wr_cnt = 0;
      pulse_start();
      send_byte(8'h00); send_byte(8'h01);
      send_byte(8'hFE); send_byte(8'h55); send_byte(8'hAA);
      chk("rec_waddr", 32'(WADDR), 0);
      chk("rec_wdata", 32'(WDATA), 32'h255AA);
`ifdef PROG_LOADER_CHECKSUM_EN
      send_byte(8'h00 ^ 8'h01 ^ 8'hFE ^ 8'h55 ^ 8'hAA);
`else
      tick();
`endif
      RX_VALID = 1'b0;
      chk("rec_done", 32'(DONE), 1);
      chk("rec_cnt", 32'(wr_cnt), 1);
      chk("rec_mem0", 32'(mem[0]), 32'h255AA);

`ifdef PROG_LOADER_CHECKSUM_EN
      pulse_start();
      send_byte(8'h00); send_byte(8'h01);
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h05);
      send_byte(8'h04);
      RX_VALID = 1'b0;
      chk("cs_ok_done", 32'(DONE), 1);
      chk("cs_ok_cpurst", 32'(CPU_RST), 0);
      pulse_start();
      send_byte(8'h00); send_byte(8'h01);
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h05);
      send_byte(8'h05);
      RX_VALID = 1'b0;
      chk("cs_bad_err", 32'(ERR), 1);
      chk("cs_bad_cpurst", 32'(CPU_RST), 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader for the RAT computer's 1024 x 18 program memory. It accepts a byte stream, typically from a UART receiver, and holds the CPU in reset while it loads. It assembles 18-bit instruction words and writes them sequentially into the program memory write port, starting at address 0. When the image is complete it releases the CPU; on a malformed image it flags an error and keeps the CPU in reset.

## Interface
Parameters:
- ADDR_W, 10, program memory address width
- DEPTH, 1024, maximum word count accepted

Ports:
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- START  in  1  one-cycle request to begin a load
- RX_DATA  in  8  incoming byte
- RX_VALID  in  1  RX_DATA valid
- RX_READY  out  1  loader accepts a byte this cycle
- WE  out  1  program memory write enable
- WADDR  out  ADDR_W  program memory write address
- WDATA  out  18  program memory write data
- CPU_RST  out  1  held high while the CPU must not run
- BUSY  out  1  load in progress
- DONE  out  1  last load completed successfully
- ERR  out  1  last load rejected

## Operation
- A byte is accepted on a rising edge where RX_VALID && RX_READY.
- Stream format, big-endian:
  - COUNT_HI, COUNT_LO: word count N, held in 16 bits.
  - N words, 3 bytes each: B0, B1, B2. Only B0[1:0] is used, so WDATA = {B0[1:0], B1, B2}. B0[7:2] is ignored.
- States: IDLE, CNT_HI, CNT_LO, W_B0, W_B1, W_B2, WRITE, (CHK), DONE_S, ERR_S.
- IDLE goes to CNT_HI on START.
- CNT_HI goes to CNT_LO on byte accept.
- CNT_LO goes to W_B0 on byte accept. If N==0 or N>DEPTH, it goes to ERR_S instead.
- W_B0 goes to W_B1, and W_B1 goes to W_B2, each on byte accept.
- W_B2 goes to WRITE on byte accept.
- WRITE lasts exactly one cycle with WE=1 and WADDR=index.
  - The index then increments.
  - If the new index == N, go to DONE_S, or to CHK when the checksum is enabled.
  - Otherwise go to W_B0.
- DONE_S and ERR_S go to CNT_HI on START. These are the only states where START restarts a load; START in any other non-IDLE state is ignored.
- Outputs by state:
  - RX_READY=1 only in CNT_HI, CNT_LO, W_B0..W_B2 and CHK.
  - BUSY=1 in every state except IDLE, DONE_S and ERR_S.
  - CPU_RST=1 whenever BUSY or in ERR_S. CPU_RST=0 in IDLE and DONE_S.
  - DONE=1 only in DONE_S. ERR=1 only in ERR_S.
- Index counter is ADDR_W+1 bits wide and reset to 0 on every START. WADDR = index[ADDR_W-1:0]. N==DEPTH writes address DEPTH-1 last and never wraps.
- WDATA holds the last assembled word between writes.
- Bytes arriving while RX_READY=0 are not consumed. The upstream holds RX_VALID.
- Mid-load RST returns to IDLE immediately. Words already written remain in memory.

## Timing
- Reset values: state IDLE, RX_READY=0, WE=0, WADDR=0, WDATA=0, CPU_RST=0, BUSY=0, DONE=0, ERR=0, index=0.
- All outputs are registered or decoded from registered state. There is no combinational path from RX_VALID to RX_READY.
- START sampled at edge t gives BUSY=1, CPU_RST=1 and RX_READY=1 from cycle t+1.
- B2 accepted at edge k gives WE=1 in cycle k+1. The next byte can be accepted at edge k+2 at the earliest.
- Peak throughput is 1 word per 4 cycles.
- The last WRITE cycle is followed directly by DONE_S (or CHK), where CPU_RST drops to 0.
- An invalid COUNT_LO accepted at edge t gives ERR=1 in cycle t+1.

## Configuration
- PROG_LOADER_CHECKSUM_EN defined:
  - After the last WRITE the FSM enters CHK and accepts one more byte.
  - The running XOR over all bytes from COUNT_HI through the final B2 is checked against that byte.
  - Equal goes to DONE_S; unequal goes to ERR_S.
  - The accumulator clears on START.
- PROG_LOADER_CHECKSUM_EN undefined: there is no CHK state and no accumulator. WRITE of the last word goes directly to DONE_S.

## Test plan
- Reset, then idle: all outputs 0. RX_VALID=1 with no START causes no accept and WE stays 0.
- START; stream 00 02, 03 12 34, 01 AB CD with RX_VALID always 1 → writes 0x31234 at WADDR 0 and 0x1ABCD at 1. Each WE is one cycle wide, RX_READY=0 during WRITE, then DONE=1 and CPU_RST=0.
- Count 04 00 (1024 words, random data, RX_VALID gaps) → last write at WADDR 0x3FF, then DONE. A count of 04 01 → ERR=1, CPU_RST=1, no WE. A count of 00 00 → ERR.
- RST asserted after 2 of 3 words → next cycle IDLE with all outputs 0. A following START plus a full 1-word image succeeds at WADDR 0.
- START pulses during a load are ignored (no restart). START while in DONE_S starts a new load with index 0.
- With PROG_LOADER_CHECKSUM_EN, image 00 01 00 00 05 plus byte 04 → DONE. The same image with trailing byte 05 → ERR=1 and CPU_RST held at 1.
